band_gain_engine: RTL
=====================

// Module: band_gain_engine
// PURPOSE
//  Shared sequential gain multiplier serving the per-band sample sequencer (start/idle/fin handshake).
//  Accepts one FIR band sample per request and scales it by that band's volume gain.
//  Rounds and saturates the product to audio width, then returns it on result.
//  The band index is tracked internally: 4 requests per frame, one per band.
// PARAMETERS
//  SAMPLE_W  24  signed audio width; operands arrive sign-extended in 32 bits
//  GAIN_W    16  unsigned gain width (one shift-add iteration per bit)
//  FRAC      14  gain fraction bits (Q2.14: 16384 = 1.0, max ~3.99994)
//  N_BANDS   4   bands per frame (band_idx width = $clog2(N_BANDS))
// PORTS
//  CLK          in   1         clock, all logic posedge
//  RESET        in   1         synchronous, active-high
//  frame_start  in   1         new audio frame (sequencer's sample_ready); band_idx := 0
//  start        in   1         request; accepted only when idle_signal=1
//  sample_feed  in   32        signed sample, sign-extended SAMPLE_W value
//  gain_0..3    in   GAIN_W    per-band gain, unsigned Q2.14
//  idle_signal  out  1         engine in IDLE, may accept start
//  fin_signal   out  1         one-cycle pulse, result valid
//  result       out  32        rounded+saturated product, sign-extended to 32
//  band_idx     out  2         band the next accepted request will use
// BEHAVIOUR
//  Reset: state=IDLE, idle_signal=1, fin_signal=0, result=0, band_idx=0, accumulator=0.
//  FSM: IDLE -> MUL (GAIN_W cycles) -> SAT (1) -> FIN (1) -> IDLE.
//   IDLE: idle_signal=1; on start=1, accept edge: latch sample_feed and gain_<band_idx>, clear acc.
//   MUL : iteration i=0..GAIN_W-1: if gain[i] then acc += sample <<< i (48-bit signed acc).
//   SAT : rnd = acc + (1<<(FRAC-1)); q = rnd >>> FRAC (round half up, toward +inf);
//         clamp q to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; register into result, sign-extended.
//   FIN : fin_signal=1 for exactly this cycle; idle_signal=0.
//  Latency: fin high in cycle accept+GAIN_W+2; back-to-back throughput GAIN_W+3 cycles/request.
//  result is held from the SAT update until the next SAT; the sequencer samples it after fin.
//  idle_signal=0 in MUL/SAT/FIN; start is ignored there (no queueing, no error).
//  start held high across the FIN->IDLE edge is accepted in the first IDLE cycle.
//  band_idx: +1 mod N_BANDS on each accept; frame_start sets it to 0.
//   frame_start and accept in the same cycle: use gain_0, band_idx becomes 1.
//   frame_start while busy: the in-flight op is unaffected; only band_idx is cleared.
//  Gain/sample changes after the accept edge do not affect the in-flight op.
//  gain=0 -> result 0. Saturation is the only overflow handling; no wrap permitted.
//  RESET mid-operation: abort, all reset values, no fin pulse emitted.
// STRUCTURE
//  audio_pkg: SAMPLE_W, GAIN_W, FRAC, N_BANDS constants; gain_eng_state_t enum
//   {IDLE, MUL, SAT, FIN}; sat_round function prototype.
//  One sub-module: round_sat (combinational: 48-bit acc -> rounded, clamped 32-bit word).
//  Top: FSM, iteration counter ($clog2(GAIN_W)+1 bits), operand latches, acc, band counter.
// TESTING
//  sample 1000, gain_0 16384 -> fin at accept+18, result 1000 (0x000003E8).
//  sample 0x500000, gain 32768 (2.0) -> result 0x007FFFFF; sample -0x600000 -> 0xFF800000.
//  Rounding: sample 3, gain 8192 -> 2; sample -3, gain 8192 -> 0xFFFFFFFF (-1).
//  Frame: frame_start+4 requests of 100, gains 16384/8192/32768/0 -> 100,50,200,0; band_idx 0->1->2->3->0.
//  start pulsed in MUL -> ignored, single fin; start held through FIN -> next accept at first IDLE cycle.
//  RESET asserted at accept+5 -> next cycle idle=1, fin never pulses, result=0, band_idx=0.

Source files
------------

// File: rtl/band_gain_engine_pkg.sv
// Shared constants, FSM state type and rounding/saturation helper for the
// band gain engine.
package audio_pkg;

  localparam int SAMPLE_W = 24;
  localparam int GAIN_W   = 16;
  localparam int FRAC     = 14;
  localparam int N_BANDS  = 4;

  localparam int ACC_W    = 48;
  localparam int BAND_W   = $clog2(N_BANDS);
  localparam int CNT_W    = $clog2(GAIN_W) + 1;

  // One extra bit over the accumulator so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1 << (FRAC-1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SAT,
    FIN
  } gain_eng_state_t;

  // Round half up, shift out the gain fraction, clamp to audio range and
  // return the value sign-extended to 32 bits.
  function automatic logic [31:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] q;
    logic        [31:0]    word;
    rnd = $signed({acc[ACC_W-1], acc}) + RND_HALF;
    q   = rnd >>> FRAC;
    if (q > SAT_MAX) begin
      word = SAT_MAX[31:0];
    end else if (q < SAT_MIN) begin
      word = SAT_MIN[31:0];
    end else begin
      word = q[31:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/band_gain_engine_round_sat.sv
// Combinational round-and-saturate stage: 48-bit product accumulator to a
// sign-extended 32-bit audio word.
module round_sat
  import audio_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic        [31:0]      word
);

  // Rounded and clamped view of the accumulator.
  always_comb begin
    word = sat_round(acc);
  end

endmodule

// File: rtl/band_gain_engine.sv
// Sequential shift-add gain multiplier shared by the four frequency bands.
// One request per band per frame; the band index advances on every accepted
// request and is cleared by frame_start.
module band_gain_engine
  import audio_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                frame_start,
  input  logic                start,
  input  logic [31:0]         sample_feed,
  input  logic [GAIN_W-1:0]   gain_0,
  input  logic [GAIN_W-1:0]   gain_1,
  input  logic [GAIN_W-1:0]   gain_2,
  input  logic [GAIN_W-1:0]   gain_3,
  output logic                idle_signal,
  output logic                fin_signal,
  output logic [31:0]         result,
  output logic [BAND_W-1:0]   band_idx
);

  gain_eng_state_t          state;
  gain_eng_state_t          state_nxt;
  logic [CNT_W-1:0]         iter_cnt;
  logic signed [ACC_W-1:0]  sample_sh;
  logic [GAIN_W-1:0]        gain_sh;
  logic signed [ACC_W-1:0]  acc;
  logic [31:0]              rs_word;
  logic [GAIN_W-1:0]        gains [N_BANDS];
  logic [GAIN_W-1:0]        gain_sel;
  logic                     accept;

  assign gains[0] = gain_0;
  assign gains[1] = gain_1;
  assign gains[2] = gain_2;
  assign gains[3] = gain_3;

  assign accept = (state == IDLE) && start;

  // Gain for the request being accepted; a coincident frame_start means band 0.
  always_comb begin
    gain_sel = gains[band_idx];
    if (frame_start) begin
      gain_sel = gains[0];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    idle_signal = 1'b0;
    fin_signal  = 1'b0;
    case (state)
      IDLE: begin
        idle_signal = 1'b1;
        if (start) begin
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (iter_cnt == CNT_W'(GAIN_W-1)) begin
          state_nxt = SAT;
        end
      end
      SAT: begin
        state_nxt = FIN;
      end
      FIN: begin
        fin_signal = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latches and shift-add datapath. Instead of indexing gain bit i and
  // shifting the sample by i, both operands are shifted one place per MUL
  // cycle so only bit 0 of the gain and the running sample are ever used.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      iter_cnt  <= '0;
      sample_sh <= '0;
      gain_sh   <= '0;
      acc       <= '0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sample_sh <= {{(ACC_W-32){sample_feed[31]}}, sample_feed};
            gain_sh   <= gain_sel;
            acc       <= '0;
            iter_cnt  <= '0;
          end
        end
        MUL: begin
          if (gain_sh[0]) begin
            acc <= acc + sample_sh;
          end
          sample_sh <= sample_sh <<< 1;
          gain_sh   <= gain_sh >> 1;
          iter_cnt  <= iter_cnt + CNT_W'(1);
        end
        SAT: begin
          result <= rs_word;
        end
        default: begin
        end
      endcase
    end
  end

  // Band counter: advances per accepted request, cleared by frame_start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      band_idx <= '0;
    end else if (frame_start) begin
      band_idx <= accept ? BAND_W'(1) : '0;
    end else if (accept) begin
      band_idx <= (band_idx == BAND_W'(N_BANDS-1)) ? '0 : band_idx + BAND_W'(1);
    end
  end

  round_sat u_round_sat (
    .acc  (acc),
    .word (rs_word)
  );

endmodule
